// File: rtl/pixel_word_unpacker_pkg.sv
// Shared types and constants for the 32-bit word to 8-bit pixel unpacker.
// Holds the FSM state enum and the lane-selection helper.
package pixel_word_unpacker_pkg;

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    localparam int PIXELS_PER_WORD = 4;
    localparam int PIXEL_W         = 8;
    localparam int WORD_W          = PIXELS_PER_WORD * PIXEL_W;

    // Emission index 0..3 maps to byte lanes 0..3 (LSB first) or 3..0 (MSB first).
    function automatic logic [PIXEL_W-1:0] pick_pixel(
        input logic [WORD_W-1:0] word,
        input logic [1:0]        idx,
        input logic              lsb_first
    );
        logic [1:0] lane;
        lane = lsb_first ? idx : ~idx;
        return word[lane*PIXEL_W +: PIXEL_W];
    endfunction

endpackage

// File: rtl/pixel_index_counter.sv
// Two-bit byte index for the unpacker: synchronous reset, clear has priority
// over increment.
module pixel_index_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       inc,
    output logic [1:0] count
);

    // NOTE: sequential state is written with <= so every register samples
    // pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= 2'd0;
        end else if (clear) begin
            count <= 2'd0;
        end else if (inc) begin
            count <= count + 2'd1;
        end
    end

endmodule

// File: rtl/pixel_word_unpacker.sv
// Accepts a 32-bit word of four pixels and emits them one per transfer, with
// zero-bubble reload of the next word on the final pixel's handshake.
module pixel_word_unpacker
    import pixel_word_unpacker_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [WORD_W-1:0]  in_word,
    output logic               in_ready,
    output logic               out_valid,
    output logic [PIXEL_W-1:0] out_pixel,
    output logic               out_last,
    input  logic               out_ready
);

    state_t            state;
    logic [WORD_W-1:0] hold;
    logic [1:0]        idx;
    logic              at_last;
    logic              in_xfer;
    logic              out_xfer;

    assign at_last  = (idx == 2'd3);
    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    // In EMIT a new word may only enter as the last pixel leaves.
    always_comb begin
        in_ready  = (state == IDLE) | (out_ready & at_last);
        out_valid = (state == EMIT);
        out_pixel = '0;
        out_last  = 1'b0;
        if (state == EMIT) begin
            out_pixel = pick_pixel(hold, idx, LSB_FIRST);
            out_last  = at_last;
        end
    end

    pixel_index_counter u_index (
        .clk   (clk),
        .reset (reset),
        .clear (in_xfer | (out_xfer & at_last)),
        .inc   (out_xfer & ~at_last),
        .count (idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            hold  <= '0;
        end else begin
            if (in_xfer) begin
                hold <= in_word;
            end
            case (state)
                IDLE: if (in_xfer) state <= EMIT;
                EMIT: if (out_xfer && at_last && !in_xfer) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_word_unpacker.sv
// Bench for pixel_word_unpacker: LSB-first and MSB-first instances share stimulus
// and are compared every cycle against a queue-of-bytes reference model.
module tb_pixel_word_unpacker;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        in_valid  = 1'b0;
    logic [31:0] in_word   = '0;
    logic        out_ready = 1'b0;

    logic       l_in_ready, l_out_valid, l_out_last;
    logic [7:0] l_out_pixel;
    logic       m_in_ready, m_out_valid, m_out_last;
    logic [7:0] m_out_pixel;

    int total = 0;
    int bad   = 0;

    // Bytes still owed by each instance, in the order they must appear.
    logic [7:0] q_lsb[$];
    logic [7:0] q_msb[$];

    always #5 clk = ~clk;

    pixel_word_unpacker #(.LSB_FIRST(1'b1)) dut_lsb (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_word   (in_word),
        .in_ready  (l_in_ready),
        .out_valid (l_out_valid),
        .out_pixel (l_out_pixel),
        .out_last  (l_out_last),
        .out_ready (out_ready)
    );

    pixel_word_unpacker #(.LSB_FIRST(1'b0)) dut_msb (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_word   (in_word),
        .in_ready  (m_in_ready),
        .out_valid (m_out_valid),
        .out_pixel (m_out_pixel),
        .out_last  (m_out_last),
        .out_ready (out_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle at the falling edge, compare outputs, then advance the model
    // to what the next rising edge should produce.
    task automatic cycle(input logic rst, input logic iv, input logic [31:0] w,
                         input logic ordy, output logic accepted);
        logic       exp_ready;
        logic       has;
        logic [7:0] exp_l, exp_m;
        @(negedge clk);
        reset     = rst;
        in_valid  = iv;
        in_word   = w;
        out_ready = ordy;
        #1;
        has       = (q_lsb.size() != 0);
        exp_ready = !has || (q_lsb.size() == 1 && ordy);
        exp_l     = has ? q_lsb[0] : 8'h00;
        exp_m     = has ? q_msb[0] : 8'h00;
        check("lsb in_ready",  32'(l_in_ready),  32'(exp_ready));
        check("lsb out_valid", 32'(l_out_valid), 32'(has));
        check("lsb out_pixel", 32'(l_out_pixel), 32'(exp_l));
        check("lsb out_last",  32'(l_out_last),  32'(q_lsb.size() == 1));
        check("msb in_ready",  32'(m_in_ready),  32'(exp_ready));
        check("msb out_valid", 32'(m_out_valid), 32'(has));
        check("msb out_pixel", 32'(m_out_pixel), 32'(exp_m));
        check("msb out_last",  32'(m_out_last),  32'(q_msb.size() == 1));
        accepted = !rst && iv && exp_ready;
        if (rst) begin
            q_lsb.delete();
            q_msb.delete();
        end else begin
            if (has && ordy) begin
                void'(q_lsb.pop_front());
                void'(q_msb.pop_front());
            end
            if (accepted) begin
                for (int k = 0; k < 4; k++) begin
                    q_lsb.push_back(w[8*k +: 8]);
                    q_msb.push_back(w[8*(3-k) +: 8]);
                end
            end
        end
    endtask

    task automatic step(input logic rst, input logic iv, input logic [31:0] w, input logic ordy);
        logic acc;
        cycle(rst, iv, w, ordy, acc);
    endtask

    // Hold a word on the input with out_ready=1 until it is taken.
    task automatic send(input logic [31:0] w);
        logic acc;
        acc = 1'b0;
        for (int n = 0; n < 20 && !acc; n++) begin
            cycle(1'b0, 1'b1, w, 1'b1, acc);
        end
        check("send accepted", 32'(acc), 32'd1);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
    endtask

    initial begin
        // Reset state.
        step(1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b1, 32'hDEADBEEF, 1'b1);

        // Single word, streaming out; both byte orders checked together.
        send(32'h44332211);
        drain(6);

        // Back-to-back words with no bubble.
        send(32'hDDCCBBAA);
        send(32'h04030201);
        drain(6);

        // Back-pressure while the second pixel is shown.
        send(32'h44332211);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'h12345678, 1'b0);
        drain(5);

        // Reset while the third pixel is shown, then a fresh word.
        send(32'h44332211);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        send(32'h000000FF);
        drain(6);

        // in_word wiggles during EMIT; only the accepted word may appear.
        send(32'h44332211);
        step(1'b0, 1'b1, $urandom, 1'b0);
        step(1'b0, 1'b1, $urandom, 1'b0);
        step(1'b0, 1'b1, $urandom, 1'b1);
        step(1'b0, 1'b1, $urandom, 1'b1);
        step(1'b0, 1'b1, $urandom, 1'b0);
        drain(6);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 39) == 0, 1'($urandom_range(0, 1)), $urandom,
                 $urandom_range(0, 3) != 0);
        end
        drain(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pixel_word_unpacker.md
PIXEL_WORD_UNPACKER -- requirements
Module: pixel_word_unpacker

Interface
REQ-001 Parameter LSB_FIRST, default 1, meaning: 1 emits byte [7:0] first, 0 emits byte [31:24] first.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  upstream presents a 32-bit word.
REQ-005 in_word  input  32  packed word of four 8-bit pixels.
REQ-006 in_ready  output  1  unpacker accepts in_word this cycle.
REQ-007 out_valid  output  1  out_pixel holds a valid pixel.
REQ-008 out_pixel  output  8  current pixel byte.
REQ-009 out_last  output  1  out_pixel is the 4th byte of its word.
REQ-010 out_ready  input  1  downstream accepts out_pixel this cycle.

Function
REQ-011 Input transfer occurs on a cycle with in_valid=1 and in_ready=1; output transfer occurs on a cycle with out_valid=1 and out_ready=1.
REQ-012 FSM has two states: IDLE (no word held) and EMIT (word held, byte index 0..3 valid).
REQ-013 In IDLE: in_ready=1, out_valid=0; an input transfer loads the holding register, clears the byte index to 0, and moves to EMIT next cycle.
REQ-014 In EMIT: out_valid=1; out_pixel = holding byte selected by index (index 0 = [7:0] if LSB_FIRST=1, else [31:24]); out_last=1 only when index=3.
REQ-015 In EMIT, an output transfer with index<3 increments the index by 1; without an output transfer, the index, holding register and outputs remain stable.
REQ-016 In EMIT, in_ready = out_ready AND (index==3), combinationally; no other cycle in EMIT asserts in_ready.
REQ-017 On the final-byte output transfer: with a simultaneous input transfer, load the new word, reset the index to 0 and stay in EMIT (zero-bubble back-to-back); otherwise return to IDLE.
REQ-018 Latency: first pixel of a word is valid the cycle after its input transfer; sustained throughput is one pixel per cycle with out_ready held at 1.
REQ-019 in_word is sampled only on an input transfer; changes on other cycles have no effect.
REQ-020 out_valid never deasserts in EMIT until the corresponding transfer completes (no pixel dropped or duplicated).
REQ-021 out_pixel and out_last are 0 while out_valid=0.

Reset
REQ-022 reset=1 at a rising edge forces state IDLE, index 0, holding register 0; outputs after that edge: out_valid=0, out_pixel=0, out_last=0, in_ready=1.
REQ-023 Reset mid-word discards all unemitted bytes; no partial word resumes after reset.
REQ-024 reset takes priority over any simultaneous input or output transfer.

Structure
REQ-025 A shared package holds the FSM state enum (IDLE, EMIT), the constant PIXELS_PER_WORD=4 and the constant PIXEL_W=8.
REQ-026 The 2-bit byte index is a sub-module pixel_index_counter with ports clk, reset, clear, inc, count[1:0]; all other logic stays in pixel_word_unpacker.

Verification
REQ-027 Reset, then in_word=0x44332211 with in_valid=1 for one cycle, out_ready=1 -> out_pixel 0x11,0x22,0x33,0x44 on four consecutive cycles, out_last=1 only on 0x44, then out_valid=0.
REQ-028 LSB_FIRST=0, same word -> pixels 0x44,0x33,0x22,0x11, out_last on 0x11.
REQ-029 Words 0xDDCCBBAA and 0x04030201 offered back-to-back, out_ready=1 -> eight pixels on eight consecutive cycles, in_ready=1 exactly on the 0xDD cycle, no bubble.
REQ-030 out_ready=0 for 3 cycles while 0x22 shown -> out_pixel stays 0x22, out_valid stays 1, in_ready=0; release -> 0x33 next.
REQ-031 reset asserted while 0x33 shown -> next cycle out_valid=0, in_ready=1; new word 0x000000FF -> first pixel 0xFF (no stale bytes).
REQ-032 in_valid=1 with changing in_word during EMIT (index<3) -> in_ready=0, emitted bytes match only the originally accepted word.
